// File: rtl/ddls_pkg.sv
// ============================================================================
//  Module  : ddls_pkg
//  Brief   : Shared types and helpers for the DDLS run sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ddls_pkg;

    // Run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_RST_REL  = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } ddls_run_state_t;

    // One-hot delay select; out-of-range indices clamp to the deepest tap.
    function automatic logic [31:0] onehot_clamp(input int unsigned idx,
                                                 input int unsigned bs);
        if (idx >= bs) begin
            return 32'd1 << (bs - 1);
        end
        return 32'd1 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddls_phase_timer.sv
// ============================================================================
//  Module  : ddls_phase_timer
//  Brief   : Loadable down-counter with a zero flag. Loaded with (length-1)
//            on phase entry; zero marks the last cycle of the phase.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ddls_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    assign zero = (count == '0);

    // Load has priority; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddls_run_ctrl.sv
// ============================================================================
//  Module  : ddls_run_ctrl
//  Brief   : Run sequencer for the DDLS delayed-reset / clock-enable stage.
//            Each accepted start performs reset hold, reset release, a
//            programmed number of enabled clock cycles, a pipeline drain and
//            a one-cycle done pulse. All outputs are registered.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ddls_run_ctrl
    import ddls_pkg::*;
#(
    parameter int BUFFERSIZE = 4,
    parameter int CNT_W      = 16,
    parameter int RST_HOLD   = 8,
    parameter int IDX_W      = $clog2(BUFFERSIZE)
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      run_cycles,
    input  logic [IDX_W-1:0]      delay_idx,
    output logic                  core_resetb_out,
    output logic                  clk_cnt_resetb_out,
    output logic                  riscv_clk_en_out,
    output logic [BUFFERSIZE-1:0] delay_sel,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      cycle_count
);

    // Timer must hold the longest phase length minus one
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int BUF_W  = $clog2(BUFFERSIZE + 2);
    localparam int TW_0   = (CNT_W > HOLD_W) ? CNT_W : HOLD_W;
    localparam int TW     = (TW_0 > BUF_W) ? TW_0 : BUF_W;

    // Drain lasts BUFFERSIZE+1 cycles
    localparam logic [TW-1:0] DRAIN_LOAD = TW'(BUFFERSIZE);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(RST_HOLD - 1);
    localparam logic [TW-1:0] REL_LOAD   = TW'(BUFFERSIZE - 1);

    ddls_run_state_t       state;
    ddls_run_state_t       nxt;
    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_zero;
    logic [CNT_W-1:0]      run_lat;
    logic [BUFFERSIZE-1:0] sel_next;
    logic                  accept;

    assign accept   = (state == ST_IDLE) && start;
    assign sel_next = BUFFERSIZE'(onehot_clamp(32'(delay_idx), 32'(BUFFERSIZE)));

    ddls_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .resetb   (resetb),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state decode; the shared timer is loaded on every phase entry
    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt      = ST_RST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end
            end
            ST_RST_HOLD: begin
                if (stop) begin
                    nxt      = ST_DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LOAD;
                end else if (tmr_zero) begin
                    nxt      = ST_RST_REL;
                    tmr_load = 1'b1;
                    tmr_val  = REL_LOAD;
                end
            end
            ST_RST_REL: begin
                if (stop || (tmr_zero && (run_lat == '0))) begin
                    nxt      = ST_DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LOAD;
                end else if (tmr_zero) begin
                    nxt      = ST_RUN;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(run_lat - CNT_W'(1));
                end
            end
            ST_RUN: begin
                // A stop on the final cycle lands in the same place
                if (stop || tmr_zero) begin
                    nxt      = ST_DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (tmr_zero) begin
                    nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt = ST_IDLE;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Run length is captured once per accepted start
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            run_lat <= '0;
        end else if (accept) begin
            run_lat <= run_cycles;
        end
    end

    // Moore outputs, updated on the edge that enters their state
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            core_resetb_out    <= 1'b0;
            clk_cnt_resetb_out <= 1'b0;
            riscv_clk_en_out   <= 1'b0;
            delay_sel          <= BUFFERSIZE'(1);
            busy               <= 1'b0;
            done               <= 1'b0;
            cycle_count        <= '0;
        end else begin
            // Resets are released on leaving RST_HOLD and stay released in IDLE
            case (nxt)
                ST_RST_HOLD: begin
                    core_resetb_out    <= 1'b0;
                    clk_cnt_resetb_out <= 1'b0;
                end
                ST_RST_REL, ST_RUN, ST_DRAIN, ST_DONE: begin
                    core_resetb_out    <= 1'b1;
                    clk_cnt_resetb_out <= 1'b1;
                end
                default: begin
                end
            endcase
            riscv_clk_en_out <= (nxt == ST_RUN);
            busy             <= (nxt != ST_IDLE);
            done             <= (nxt == ST_DONE);
            // cycle_count counts completed RUN cycles and saturates
            if (accept) begin
                delay_sel   <= sel_next;
                cycle_count <= '0;
            end else if ((state == ST_RUN) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddls_run_ctrl.sv
// ============================================================================
//  Module  : tb_ddls_run_ctrl
//  Brief   : Self-checking bench for ddls_run_ctrl. A timeline model (cycle
//            index since acceptance, drain start index) predicts every output
//            each cycle; directed runs pin the model with literal values.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ddls_run_ctrl;

    localparam int HOLD_END = 8;   // RST_HOLD
    localparam int REL_END  = 12;  // RST_HOLD + BUFFERSIZE
    localparam int DRAIN_N  = 5;   // BUFFERSIZE + 1

    logic        clk        = 1'b0;
    logic        resetb     = 1'b0;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic [15:0] run_cycles = '0;
    logic [2:0]  delay_idx  = '0;

    logic        core_resetb_out;
    logic        clk_cnt_resetb_out;
    logic        riscv_clk_en_out;
    logic [3:0]  delay_sel;
    logic        busy;
    logic        done;
    logic [15:0] cycle_count;

    int tests = 0;
    int fails = 0;
    int total_done = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ddls_run_ctrl #(
        .BUFFERSIZE (4),
        .CNT_W      (16),
        .RST_HOLD   (8),
        .IDX_W      (3)
    ) dut (
        .clk                (clk),
        .resetb             (resetb),
        .start              (start),
        .stop               (stop),
        .run_cycles         (run_cycles),
        .delay_idx          (delay_idx),
        .core_resetb_out    (core_resetb_out),
        .clk_cnt_resetb_out (clk_cnt_resetb_out),
        .riscv_clk_en_out   (riscv_clk_en_out),
        .delay_sel          (delay_sel),
        .busy               (busy),
        .done               (done),
        .cycle_count        (cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // m_k: cycles since acceptance; m_d: cycle index at which DRAIN begins.
    bit         m_active = 1'b0;
    bit         m_ran    = 1'b0;
    int         m_k      = 0;
    int         m_d      = 0;
    int         m_last   = 0;
    logic [3:0] m_sel    = 4'b0001;
    logic [3:0] m_one    = 4'b0001;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_active = 1'b0;
            m_ran    = 1'b0;
            m_k      = 0;
            m_d      = 0;
            m_last   = 0;
            m_sel    = 4'b0001;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_k      = 0;
                m_d      = REL_END + int'(run_cycles);
                m_sel    = (delay_idx >= 3'd4) ? 4'b1000 : (m_one << delay_idx);
            end
        end else if (m_k == m_d + DRAIN_N) begin
            m_active = 1'b0;
            m_ran    = 1'b1;
            m_last   = (m_d > REL_END) ? m_d - REL_END : 0;
        end else begin
            if (stop && (m_k < m_d)) m_d = m_k + 1;
            m_k++;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_rst, e_en, e_busy, e_done;
        int   e_cnt;
        if (done) total_done++;
        if (chk_en) begin
            if (m_active && (m_k < m_d)) begin
                e_rst  = (m_k >= HOLD_END);
                e_en   = (m_k >= REL_END);
                e_busy = 1'b1;
                e_done = 1'b0;
                e_cnt  = (m_k > REL_END) ? m_k - REL_END : 0;
            end else if (m_active) begin
                e_rst  = 1'b1;
                e_en   = 1'b0;
                e_busy = 1'b1;
                e_done = (m_k == m_d + DRAIN_N);
                e_cnt  = (m_d > REL_END) ? m_d - REL_END : 0;
            end else begin
                e_rst  = m_ran;
                e_en   = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_cnt  = m_last;
            end
            check("m_core_resetb", core_resetb_out, e_rst);
            check("m_clk_cnt_resetb", clk_cnt_resetb_out, e_rst);
            check("m_clk_en", riscv_clk_en_out, e_en);
            check("m_busy", busy, e_busy);
            check("m_done", done, e_done);
            check("m_cycle_count", cycle_count, e_cnt);
            check("m_delay_sel", delay_sel, m_sel);
        end
    end

    // One run: k=0 is the first cycle after the accepting edge
    task automatic do_run(input logic [15:0] rc, input logic [2:0] idx,
                          input int stop_at, input int restart_at,
                          output int en_rise, output int en_cnt, output int done_at,
                          output int done_cnt, output int low_cnt, output logic [3:0] sel0);
        bit fin;
        fin      = 1'b0;
        en_rise  = -1;
        en_cnt   = 0;
        done_at  = -1;
        done_cnt = 0;
        low_cnt  = 0;
        @(negedge clk);
        start      = 1'b1;
        run_cycles = rc;
        delay_idx  = idx;
        @(negedge clk);
        start = 1'b0;
        sel0  = delay_sel;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (riscv_clk_en_out) begin
                if (en_rise < 0) en_rise = k;
                en_cnt++;
            end
            if (!core_resetb_out) low_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (done_cnt > 0 && !busy) fin = 1'b1;
            stop  = (k == stop_at);
            start = (k == restart_at);
            if (k == restart_at) begin
                run_cycles = 16'd50;
                delay_idx  = 3'd0;
            end
            if (!fin) @(negedge clk);
        end
        stop  = 1'b0;
        start = 1'b0;
        check("run_completes", fin, 1'b1);
    endtask

    initial begin
        int er, ec, da, dc, lc, d0;
        logic [3:0] s0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_core_resetb", core_resetb_out, 1'b0);
        check("rst_clk_cnt_resetb", clk_cnt_resetb_out, 1'b0);
        check("rst_clk_en", riscv_clk_en_out, 1'b0);
        check("rst_delay_sel", delay_sel, 4'b0001);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cycle_count", cycle_count, 16'd0);
        chk_en = 1'b1;
        resetb = 1'b1;

        // Basic run: enable 5 cycles starting 12 after acceptance,
        // done 6 cycles after the last enabled cycle
        do_run(16'd5, 3'd2, -1, -1, er, ec, da, dc, lc, s0);
        check("t2_sel", s0, 4'b0100);
        check("t2_low_cycles", lc, 8);
        check("t2_en_rise", er, 12);
        check("t2_en_cycles", ec, 5);
        check("t2_done_at", da, 22);
        check("t2_done_cnt", dc, 1);
        check("t2_cycle_count", cycle_count, 16'd5);

        // Zero-length run
        do_run(16'd0, 3'd1, -1, -1, er, ec, da, dc, lc, s0);
        check("t3_sel", s0, 4'b0010);
        check("t3_en_cycles", ec, 0);
        check("t3_done_at", da, 17);
        check("t3_cycle_count", cycle_count, 16'd0);

        // Stop during the 3rd RUN cycle
        do_run(16'd100, 3'd0, 14, -1, er, ec, da, dc, lc, s0);
        check("t4_en_cycles", ec, 3);
        check("t4_done_at", da, 20);
        check("t4_done_cnt", dc, 1);
        check("t4_cycle_count", cycle_count, 16'd3);

        // Clamped index and a start while busy
        do_run(16'd3, 3'd7, -1, 5, er, ec, da, dc, lc, s0);
        check("t5_sel", s0, 4'b1000);
        check("t5_en_cycles", ec, 3);
        check("t5_done_at", da, 20);
        check("t5_done_cnt", dc, 1);
        check("t5_sel_after", delay_sel, 4'b1000);

        // Stop during RST_HOLD releases resets on entering DRAIN
        do_run(16'd10, 3'd3, 3, -1, er, ec, da, dc, lc, s0);
        check("th_low_cycles", lc, 4);
        check("th_en_cycles", ec, 0);
        check("th_done_at", da, 9);
        check("th_core_resetb", core_resetb_out, 1'b1);

        // Stop coinciding with the final RUN cycle
        do_run(16'd4, 3'd1, 15, -1, er, ec, da, dc, lc, s0);
        check("tf_en_cycles", ec, 4);
        check("tf_done_at", da, 21);
        check("tf_cycle_count", cycle_count, 16'd4);

        // Asynchronous reset mid-run
        @(negedge clk);
        start      = 1'b1;
        run_cycles = 16'd10;
        delay_idx  = 3'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("t6_running", riscv_clk_en_out, 1'b1);
        d0 = total_done;
        #2 resetb = 1'b0;
        #1;
        check("t6_core_resetb", core_resetb_out, 1'b0);
        check("t6_clk_cnt_resetb", clk_cnt_resetb_out, 1'b0);
        check("t6_clk_en", riscv_clk_en_out, 1'b0);
        check("t6_delay_sel", delay_sel, 4'b0001);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_cycle_count", cycle_count, 16'd0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_done", total_done, d0);
        do_run(16'd2, 3'd1, -1, -1, er, ec, da, dc, lc, s0);
        check("t6_rerun_done_cnt", dc, 1);
        check("t6_rerun_cycle_count", cycle_count, 16'd2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
